// File: rtl/sigma_delta_decimator.sv
// -----------------------------------------------------------------------------
// sigma_delta_decimator
//
// Stereo 3rd-order CIC decimator for 1-bit sigma-delta modulator streams.
// Each channel runs three wrapping integrators at the bit-clock rate, then
// three differential-delay-1 combs once per decimation period. The two
// channels share one phase counter, one warm-up counter and one strobe.
//
// Ports
//   ana_clk       in   modulator bit clock (the only clock, rising edge)
//   rst           in   asynchronous active-high reset
//   en            in   enable; when low every register holds
//   ana_l, ana_r  in   left/right modulator bitstreams (1 -> +1, 0 -> -1)
//   dig_l, dig_r  out  decimated two's-complement samples, OUT_W bits
//   ok_to_sample  out  one-cycle strobe; dig_l/dig_r are stable while high
// -----------------------------------------------------------------------------
module sigma_delta_decimator #(
    parameter int DEC_RATIO = 64,
    parameter int OUT_W     = 20
) (
    input  logic                    ana_clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ana_l,
    input  logic                    ana_r,
    output logic signed [OUT_W-1:0] dig_l,
    output logic signed [OUT_W-1:0] dig_r,
    output logic                    ok_to_sample
);

    localparam int              PH_W    = (DEC_RATIO > 1) ? $clog2(DEC_RATIO) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC_RATIO - 1);

    localparam logic signed [OUT_W-1:0] PLUS_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic signed [OUT_W-1:0] MINUS_ONE = {OUT_W{1'b1}};

    logic [PH_W-1:0] phase;
    logic [1:0]      warm;
    logic            tick;
    logic            ok_p1;

    // Modulator bit to +/-1 sample.
    function automatic logic signed [OUT_W-1:0] map_bit(input logic b);
        return b ? PLUS_ONE : MINUS_ONE;
    endfunction

    assign tick = en && (phase == PH_LAST);

    // Shared control: phase counter, warm-up count and strobe register.
    always_ff @(posedge ana_clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            warm  <= '0;
            ok_p1 <= 1'b0;
        end else begin
            // Captured every cycle (not only when enabled) so a pulse
            // swallowed by a low en is dropped rather than deferred.
            ok_p1 <= tick && (warm == 2'd3);
            if (en) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                if (tick && (warm != 2'd3)) begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

    // Strobe is masked by en so it is never high while the block is frozen.
    assign ok_to_sample = ok_p1 & en;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic                    bit_in;
        logic signed [OUT_W-1:0] integ1_p0, integ2_p0, integ3_p0;
        logic signed [OUT_W-1:0] dly1, dly2, dly3;
        logic signed [OUT_W-1:0] comb1, comb2, comb3;
        logic signed [OUT_W-1:0] dig_p1;

        assign bit_in = (ch == 0) ? ana_l : ana_r;

        // Comb section is combinational off the registered I3 and is only
        // committed on the tick cycle.
        always_comb begin
            comb1 = integ3_p0 - dly1;
            comb2 = comb1 - dly2;
            comb3 = comb2 - dly3;
        end

        // Stage p0: integrators at bit rate (modulo 2^OUT_W wrap is intended).
        always_ff @(posedge ana_clk or posedge rst) begin
            if (rst) begin
                integ1_p0 <= '0;
                integ2_p0 <= '0;
                integ3_p0 <= '0;
            end else if (en) begin
                integ1_p0 <= integ1_p0 + map_bit(bit_in);
                integ2_p0 <= integ2_p0 + integ1_p0;
                integ3_p0 <= integ3_p0 + integ2_p0;
            end
        end

        // Stage p1: comb delays and output register at decimated rate.
        always_ff @(posedge ana_clk or posedge rst) begin
            if (rst) begin
                dly1   <= '0;
                dly2   <= '0;
                dly3   <= '0;
                dig_p1 <= '0;
            end else if (tick) begin
                dly1   <= integ3_p0;
                dly2   <= comb1;
                dly3   <= comb2;
                dig_p1 <= comb3;
            end
        end

        if (ch == 0) begin : g_left
            assign dig_l = dig_p1;
        end else begin : g_right
            assign dig_r = dig_p1;
        end
    end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_decimator
//
// Scoreboard bench. The driver applies one bit-clock of stimulus per step and
// advances a reference model built from unbounded running sums: the sampled
// third integral at each tick feeds a third-difference formula, reduced to
// 20 bits at the end. Expected strobes are queued with the cycle they must
// appear in; a negedge monitor pops and compares whenever ok_to_sample is high,
// and also checks the held outputs every cycle.
// -----------------------------------------------------------------------------
module tb_sigma_delta_decimator;

    localparam int R = 64;

    logic clk = 1'b0;
    logic rst, en, ana_l, ana_r;
    logic signed [19:0] dig_l, dig_r;
    logic ok_to_sample;

    sigma_delta_decimator #(.DEC_RATIO(R), .OUT_W(20)) dut (
        .ana_clk      (clk),
        .rst          (rst),
        .en           (en),
        .ana_l        (ana_l),
        .ana_r        (ana_r),
        .dig_l        (dig_l),
        .dig_r        (dig_r),
        .ok_to_sample (ok_to_sample)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [19:0] l;
        logic signed [19:0] r;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   first_pulse = -1;

    // Reference model state (unbounded sums; reduced to 20 bits on output)
    longint             s1[2], s2[2], s3[2];
    longint             hist[2][4];
    int                 m_ph, m_warm;
    bit                 pending;
    logic signed [19:0] m_dig[2];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            s1[ch] = 0; s2[ch] = 0; s3[ch] = 0;
            for (int k = 0; k < 4; k++) hist[ch][k] = 0;
            m_dig[ch] = '0;
        end
        m_ph = 0;
        m_warm = 0;
        pending = 1'b0;
        first_pulse = -1;
        sb.delete();
    endfunction

    // One enabled bit-clock: on a tick the third integral (value held before
    // this cycle's accumulation) is sampled and third-differenced.
    function automatic void model_clock(input logic e, input logic l, input logic r);
        longint y;
        logic   b;
        if (!e) return;
        if (m_ph == R - 1) begin
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch][3] = hist[ch][2];
                hist[ch][2] = hist[ch][1];
                hist[ch][1] = hist[ch][0];
                hist[ch][0] = s3[ch];
                y = hist[ch][0] - 3 * hist[ch][1] + 3 * hist[ch][2] - hist[ch][3];
                m_dig[ch] = y[19:0];
            end
            pending = (m_warm == 3);
            if (m_warm < 3) m_warm++;
        end
        for (int ch = 0; ch < 2; ch++) begin
            b = (ch == 0) ? l : r;
            s3[ch] = s3[ch] + s2[ch];
            s2[ch] = s2[ch] + s1[ch];
            s1[ch] = s1[ch] + (b ? 64'sd1 : -64'sd1);
        end
        m_ph = (m_ph + 1) % R;
    endfunction

    task automatic step(input logic e, input logic l, input logic r);
        en = e; ana_l = l; ana_r = r;
        if (pending && e) begin
            exp_t t;
            t.l = m_dig[0];
            t.r = m_dig[1];
            t.cyc = cyc;
            sb.push_back(t);
        end
        pending = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        model_clock(e, l, r);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_dig_l", dig_l, 0);
        check("rst_dig_r", dig_r, 0);
        check("rst_ok", ok_to_sample, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("hold_dig_l", dig_l, m_dig[0]);
            check("hold_dig_r", dig_r, m_dig[1]);
            if (en === 1'b0) check("ok_while_en_low", ok_to_sample, 0);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_pulse_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (ok_to_sample === 1'b1) begin
                if (first_pulse < 0) first_pulse = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    exp_t t;
                    t = sb.pop_front();
                    check("pulse_cycle", cyc, t.cyc);
                    check("pulse_dig_l", dig_l, t.l);
                    check("pulse_dig_r", dig_r, t.r);
                end
            end
        end
    end

    initial begin
        int base;
        int guard;
        logic alt;

        rst = 1'b1; en = 1'b0; ana_l = 1'b0; ana_r = 1'b0;
        model_reset();
        #1;
        check("init_dig_l", dig_l, 0);
        check("init_dig_r", dig_r, 0);
        check("init_ok", ok_to_sample, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Constant ones on both channels: first strobe in enabled cycle 257.
        base = cyc;
        for (int i = 0; i < 10 * R; i++) step(1'b1, 1'b1, 1'b1);
        check("first_pulse_cycle", first_pulse - base, 256);
        check("dc_ones_l", dig_l, 262144);
        check("dc_ones_r", dig_r, 262144);

        // Left ones, right zeros.
        for (int i = 0; i < 10 * R; i++) step(1'b1, 1'b1, 1'b0);
        check("split_l", dig_l, 262144);
        check("split_r", dig_r, -262144);

        // Alternating 1010 on both channels.
        alt = 1'b1;
        for (int i = 0; i < 10 * R; i++) begin
            step(1'b1, alt, alt);
            alt = ~alt;
        end
        check("alt_l", dig_l, 0);
        check("alt_r", dig_r, 0);

        // en low in the cycle right after a qualifying tick: pulse dropped.
        guard = 0;
        while (!pending && guard < 4 * R) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("reach_tick", pending, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // en low for 10 cycles mid-period.
        guard = 0;
        while (m_ph != 20 && guard < 2 * R) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("reach_phase20", m_ph, 20);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 1'($urandom));

        // Random bitstreams with occasional enable drop-outs.
        for (int i = 0; i < 30 * R; i++)
            step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom));

        // Reset at phase 30 after six ticks, then restart timing.
        #2 rst = 1'b1;
        #1 model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6 * R + 30; i++) step(1'b1, 1'b1, 1'b1);
        check("pre_reset_nonzero", (dig_l != 0), 1);
        async_reset();
        base = cyc;
        for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1, 1'b1);
        check("post_reset_first_pulse", first_pulse - base, 256);

        // Long constant-ones run: integrators wrap many times.
        for (int i = 0; i < 300 * R; i++) step(1'b1, 1'b1, 1'b1);
        check("long_dc_l", dig_l, 262144);
        check("long_dc_r", dig_r, 262144);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
        check("queue_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 Parameter: DEC_RATIO, default 64, decimation ratio; power of two in 4..64.
REQ-002 Parameter: OUT_W, default 20, output sample width; fixed at 20.
REQ-003 Port: ana_clk  input  1  modulator bit clock; the only clock; all state on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: en  input  1  enable; when low, all state holds.
REQ-006 Port: ana_l  input  1  left sigma-delta modulator bitstream.
REQ-007 Port: ana_r  input  1  right sigma-delta modulator bitstream.
REQ-008 Port: dig_l  output  20  left decimated sample, two's complement.
REQ-009 Port: dig_r  output  20  right decimated sample, two's complement.
REQ-010 Port: ok_to_sample  output  1  one-cycle strobe; dig_l/dig_r are stable at its rising edge.

Function
REQ-011 Each channel SHALL be an independent 3rd-order CIC decimator: three integrators at ana_clk rate, then three combs (differential delay 1) at decimated rate.
REQ-012 Input mapping SHALL be: bit 1 -> +1, bit 0 -> -1, as 20-bit signed.
REQ-013 Integrators and combs SHALL be 20 bits wide and wrap modulo 2^20; no saturation.
REQ-014 Each integrator SHALL be a register updated every enabled cycle: I1 += x, I2 += I1, I3 += I2, using previous-cycle register values.
REQ-015 A phase counter SHALL count 0..DEC_RATIO-1 on enabled cycles and wrap to 0; the tick cycle is phase == DEC_RATIO-1.
REQ-016 On a tick cycle, the registered I3 value SHALL pass through the three combs (y = x - x_delayed), updating the comb delay registers, and the result SHALL be registered into dig_l/dig_r at the end of that cycle.
REQ-017 dig_l/dig_r SHALL change only at the end of tick cycles and otherwise hold.
REQ-018 ok_to_sample SHALL be high for exactly the one cycle after a qualifying tick, then low for at least DEC_RATIO-1 cycles.
REQ-019 Warm-up: the first 3 ticks after reset SHALL update dig_l/dig_r but SHALL NOT produce an ok_to_sample pulse; the 4th and later ticks SHALL produce a pulse.
REQ-020 The warm-up tick count SHALL saturate at 3.
REQ-021 en low: phase counter, integrators, combs, warm-up count and dig outputs SHALL hold, and ok_to_sample SHALL be 0.
REQ-022 If en is low in the cycle after a tick, no pulse SHALL be emitted for that tick, and the pulse SHALL NOT be deferred.
REQ-023 Steady state SHALL be: DC input of all 1s -> +DEC_RATIO^3; all 0s -> -DEC_RATIO^3; alternating 1010 -> 0.
REQ-024 For DEC_RATIO < 64, the comb output SHALL be presented unscaled as a 20-bit sign-extended value.
REQ-025 Left and right channels SHALL share the phase counter, warm-up count and ok_to_sample, and SHALL tick on the same cycle.

Reset
REQ-026 rst high SHALL immediately clear all integrators, comb delays, phase counter and warm-up count, set dig_l = dig_r = 0 and ok_to_sample = 0, independent of ana_clk.
REQ-027 rst asserted mid-decimation-period SHALL discard the partial period, and after release the first tick SHALL occur on the DEC_RATIO-th enabled cycle.
REQ-028 Release of rst SHALL restart warm-up, so no pulse occurs until the 4th post-reset tick.

Verification
REQ-029 Reset, en = 1, ana_l = ana_r = 1 constant -> first ok_to_sample high in enabled cycle 257 (ticks at cycles 64, 128, 192, 256); from the second pulse onward, dig_l = dig_r = 262144.
REQ-030 ana_l = 1 constant, ana_r = 0 constant -> after warm-up, dig_l = 262144 and dig_r = -262144 (0xC0000) at every pulse.
REQ-031 ana_l = ana_r alternating 1,0,1,0 -> after warm-up, dig_l = dig_r = 0 at every pulse; pulse spacing is exactly 64 cycles.
REQ-032 en deasserted for 10 cycles mid-period -> next pulse delayed by exactly 10 cycles; outputs held and ok_to_sample = 0 while en is low.
REQ-033 rst pulsed at phase 30 after 6 ticks -> outputs go to 0 immediately; the next pulse arrives 257 enabled cycles after release.
REQ-034 Constant-1 input run for 10,000 ticks -> output stays 262144, confirming wrap-around correctness of the integrators.
